instr_fetch_queue: RTL and testbench

- Instruction queue directly downstream of the direct-mapped instruction cache.
- Each cycle the cache asserts a hit, fetch pushes one {pc, instruction} pair; decode pops in order.
- Decouples fetch from decode stalls and throttles fetch when full.
- Supports a single-cycle flush for redirects (branch mispredict or jump), discarding all queued instructions.

---
 rtl/instr_fetch_queue.sv | 94 +++++++++
 tb/tb_instr_fetch_queue.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction queue between the instruction cache and decode: a circular buffer of
// {pc, instr} pairs with a single-cycle flush for redirects.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module instr_fetch_queue #(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
   localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [ADDR_WIDTH-1:0] in_pc,
   input  logic [DATA_WIDTH-1:0] in_instr,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [DATA_WIDTH-1:0] out_instr,
   input  logic                  out_ready,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  overflow_err
);

   localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Unsupported depths elaborate a module that does not exist.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      instr_fetch_queue_depth_must_be_pow2_ge2 u_bad_depth ();
   end

   logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_WIDTH-1:0]             wr_ptr;
   logic [PTR_WIDTH-1:0]             rd_ptr;
   logic                             full;
   logic                             empty;
   logic                             push;
   logic                             pop;

   always_comb begin
      full      = (count == CNT_WIDTH'(DEPTH));
      empty     = (count == '0);
      in_ready  = ~full;
      out_valid = ~empty;
      push      = in_valid & in_ready & ~flush;
      pop       = out_valid & out_ready & ~flush;
   end

   assign {out_pc, out_instr} = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wr_ptr] <= {in_pc, in_instr};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow_err <= 1'b0;
      end else begin
         if (in_valid && !in_ready && !flush) begin
            overflow_err <= 1'b1;
         end
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            case ({push, pop})
               2'b10:   count <= count + CNT_WIDTH'(1);
               2'b01:   count <= count - CNT_WIDTH'(1);
               default: count <= count;
            endcase
         end
      end
   end

   a_count_bound: assert property (@(posedge clk) disable iff (rst)
      count <= CNT_WIDTH'(DEPTH));
   a_ptr_count: assert property (@(posedge clk) disable iff (rst)
      PTR_WIDTH'(wr_ptr - rd_ptr) == count[PTR_WIDTH-1:0]);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: ordering, full/overflow, wrap-around,
// simultaneous push/pop, flush and mid-stream reset.
module tb_instr_fetch_queue;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic [AW-1:0] in_pc;
   logic [DW-1:0] in_instr;
   logic          in_ready;
   logic          out_valid;
   logic [AW-1:0] out_pc;
   logic [DW-1:0] out_instr;
   logic          out_ready;
   logic [CW-1:0] count;
   logic          overflow_err;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   instr_fetch_queue #(
      .DEPTH     (DEPTH),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_pc       (in_pc),
      .in_instr    (in_instr),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_pc      (out_pc),
      .out_instr   (out_instr),
      .out_ready   (out_ready),
      .count       (count),
      .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [AW-1:0] pc, input logic [DW-1:0] instr);
      in_valid = 1'b1;
      in_pc    = pc;
      in_instr = instr;
      tick();
      in_valid = 1'b0;
   endtask

   // Pops n entries, expecting PCs base+4*i and instrs ibase+i at the head.
   task automatic drain(input int unsigned n, input logic [AW-1:0] base, input logic [DW-1:0] ibase,
                        input string tag);
      out_ready = 1'b1;
      for (int unsigned i = 0; i < n; i++) begin
         check({tag, "_valid"}, out_valid, 1);
         check({tag, "_pc"}, out_pc, base + AW'(4 * i));
         check({tag, "_instr"}, out_instr, ibase + DW'(i));
         tick();
      end
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_count", count, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_overflow", overflow_err, 0);

      // 1: basic ordering, no same-cycle bypass
      in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'hA0;
      check("t1_no_bypass", out_valid, 0);
      tick();
      in_valid = 1'b0;
      check("t1_first_visible", out_pc, 32'h100);
      push_one(32'h104, 32'hA1);
      push_one(32'h108, 32'hA2);
      check("t1_count3", count, 3);
      check("t1_head_pc", out_pc, 32'h100);
      check("t1_head_instr", out_instr, 32'hA0);
      drain(3, 32'h100, 32'hA0, "t1_pop");
      check("t1_empty", out_valid, 0);
      check("t1_count0", count, 0);

      // 2: fill, overflow, pop restores in_ready
      for (int unsigned i = 0; i < 8; i++) push_one(32'h400 + 4 * i, 32'hB0 + i);
      check("t2_count8", count, 8);
      check("t2_full_ready", in_ready, 0);
      check("t2_no_overflow_yet", overflow_err, 0);
      push_one(32'h4FF, 32'hBF);
      check("t2_count_still8", count, 8);
      check("t2_overflow", overflow_err, 1);
      check("t2_head_kept", out_pc, 32'h400);
      // full queue refuses a push even with a same-cycle pop
      out_ready = 1'b1;
      push_one(32'h4FE, 32'hBE);
      out_ready = 1'b0;
      check("t2_ready_after_pop", in_ready, 1);
      check("t2_count7", count, 7);
      drain(7, 32'h404, 32'hB1, "t2_pop");
      check("t2_ninth_absent", out_valid, 0);
      check("t2_overflow_sticky", overflow_err, 1);

      // 3: wrap-around
      for (int unsigned i = 0; i < 6; i++) push_one(32'h500 + 4 * i, 32'h50 + i);
      drain(6, 32'h500, 32'h50, "t3_pre");
      for (int unsigned i = 0; i < 8; i++) push_one(32'h200 + 4 * i, 32'hC0 + i);
      check("t3_count8", count, 8);
      drain(8, 32'h200, 32'hC0, "t3_wrap");
      check("t3_empty", out_valid, 0);

      // 4: simultaneous push/pop at count=4
      for (int unsigned i = 0; i < 4; i++) push_one(32'h600 + 4 * i, 32'hD0 + i);
      out_ready = 1'b1;
      for (int unsigned k = 0; k < 10; k++) begin
         check("t4_head_pc", out_pc, 32'h600 + 4 * k);
         check("t4_head_instr", out_instr, 32'hD0 + k);
         push_one(32'h600 + 4 * (k + 4), 32'hD0 + k + 4);
         check("t4_count4", count, 4);
      end
      out_ready = 1'b0;
      check("t4_final_head", out_pc, 32'h628);

      // 5: flush dominates push and pop
      push_one(32'h638, 32'hDE);
      check("t5_count5", count, 5);
      flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h6FC; in_instr = 32'hEE;
      check("t5_ready_in_flush", in_ready, 1);
      tick();
      flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      check("t5_count0", count, 0);
      check("t5_out_valid", out_valid, 0);
      push_one(32'h300, 32'hF0);
      check("t5_count1", count, 1);
      check("t5_head_pc", out_pc, 32'h300);
      check("t5_head_instr", out_instr, 32'hF0);

      // 6: reset mid-stream
      for (int unsigned i = 0; i < 5; i++) push_one(32'h700 + 4 * i, 32'h70 + i);
      check("t6_count6", count, 6);
      rst = 1'b1; in_valid = 1'b1; in_pc = 32'h7FC; out_ready = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("t6_count0", count, 0);
      check("t6_out_valid", out_valid, 0);
      check("t6_in_ready", in_ready, 1);
      check("t6_overflow_clr", overflow_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
